// File: rtl/d_latch.sv
`default_nettype none
// ============================================================================
// Module      : d_latch
// Description : Gated data-capture primitive. Q is a purely combinational
//               gated copy of D; a clocked hold register keeps the last
//               enabled D, with a change pulse and a saturating update
//               counter for debug visibility.
// Revision    : 1.0  initial release
// ============================================================================
module d_latch #(
  parameter int WIDTH     = 1,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     D,
  input  logic                 enable,
  output logic [WIDTH-1:0]     Q,
  output logic [WIDTH-1:0]     q_hold,
  output logic                 changed,
  output logic [CNT_WIDTH-1:0] upd_cnt
);

  // Counter ceiling: all ones at the configured width.
  localparam logic [CNT_WIDTH-1:0] c_cnt_max = {CNT_WIDTH{1'b1}};

  logic                 w_gate_open;
  logic                 w_differs;
  logic                 w_cnt_sat;
  logic [WIDTH-1:0]     w_q;
  logic [WIDTH-1:0]     r_hold;
  logic                 r_changed;
  logic [CNT_WIDTH-1:0] r_cnt;

  // Reset gates Q as well, so Q drops in the same timestep rst_n falls.
  assign w_gate_open = rst_n & enable;
  assign w_differs   = (D != r_hold);
  assign w_cnt_sat   = (r_cnt == c_cnt_max);

  // Gated output path: transparent when open, forced low otherwise, no storage.
  always_comb begin
    w_q = '0;
    if (w_gate_open) begin
      w_q = D;
    end
  end

  // Hold register: captures D on every enabled edge, otherwise keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold <= '0;
    end else if (enable) begin
      r_hold <= D;
    end
  end

  // Change pulse: compares incoming D with the value currently held, so the
  // first capture after reset is judged against zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_changed <= 1'b0;
    end else begin
      r_changed <= enable & w_differs;
    end
  end

  // Update counter: one count per enabled edge, sticking at all ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (enable && !w_cnt_sat) begin
      r_cnt <= r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  assign Q       = w_q;
  assign q_hold  = r_hold;
  assign changed = r_changed;
  assign upd_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_d_latch.sv
`default_nettype none
// ============================================================================
// Module      : tb_d_latch
// Description : Self-checking bench for d_latch with randomized stimulus and
//               a history-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_d_latch;

  localparam int WIDTH     = 8;
  localparam int CNT_WIDTH = 4;
  localparam int CNT_MAX   = (1 << CNT_WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [WIDTH-1:0]     D;
  logic                 enable;
  logic [WIDTH-1:0]     Q;
  logic [WIDTH-1:0]     q_hold;
  logic                 changed;
  logic [CNT_WIDTH-1:0] upd_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  d_latch #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .D       (D),
    .enable  (enable),
    .Q       (Q),
    .q_hold  (q_hold),
    .changed (changed),
    .upd_cnt (upd_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a history of captured values and a count of enabled
  // edges since the last reset; expected outputs are derived from these.
  logic [WIDTH-1:0] m_caps[$];
  int               m_edges   = 0;
  bit               m_changed = 1'b0;

  function automatic logic [WIDTH-1:0] m_hold();
    return (m_caps.size() == 0) ? '0 : m_caps[$];
  endfunction

  function automatic int m_cnt();
    return (m_edges > CNT_MAX) ? CNT_MAX : m_edges;
  endfunction

  function automatic logic [WIDTH-1:0] m_q();
    return (rst_n === 1'b1 && enable === 1'b1) ? D : '0;
  endfunction

  // Model update on the same events that matter to the design.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_caps.delete();
      m_edges   = 0;
      m_changed = 1'b0;
    end else if (enable) begin
      m_changed = (D != m_hold());
      m_caps.push_back(D);
      if (m_caps.size() > 4) void'(m_caps.pop_front());
      m_edges++;
    end else begin
      m_changed = 1'b0;
    end
  end

  // Compare every cycle on the falling edge, away from the capture edge.
  always @(negedge clk) begin
    chk("cyc_q",       32'(Q),       32'(m_q()));
    chk("cyc_q_hold",  32'(q_hold),  32'(m_hold()));
    chk("cyc_changed", 32'(changed), 32'(m_changed));
    chk("cyc_upd_cnt", 32'(upd_cnt), 32'(m_cnt()));
  end

  // Move to a safe point just after the next rising edge.
  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  task automatic reset_pulse();
    after_edge();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    D      = 8'h01;
    enable = 1'b1;
    #1;
    // Reset state with D=1, enable=1.
    chk("rst_q",       32'(Q),       32'h0);
    chk("rst_q_hold",  32'(q_hold),  32'h0);
    chk("rst_changed", 32'(changed), 32'h0);
    chk("rst_upd_cnt", 32'(upd_cnt), 32'h0);
    after_edge();
    after_edge();
    chk("rst_held_cnt", 32'(upd_cnt), 32'h0);
    rst_n = 1'b1;
    #1;
    chk("release_q", 32'(Q), 32'h01);

    // Transparency: Q follows D within the timestep, no edge needed.
    enable = 1'b1;
    for (int i = 0; i < 50; i++) begin
      after_edge();
      D = WIDTH'($urandom);
      #1;
      chk("transp_q", 32'(Q), 32'(D));
      D = WIDTH'($urandom);
      #1;
      chk("transp_q", 32'(Q), 32'(D));
    end

    // Gating: Q forced low, state frozen.
    after_edge();
    enable = 1'b0;
    for (int i = 0; i < 20; i++) begin
      after_edge();
      D = WIDTH'($urandom);
      #1;
      chk("gate_q", 32'(Q), 32'h0);
    end

    // Capture/hold with hand-computed values.
    D = 8'h00; enable = 1'b1;
    after_edge();
    D = 8'h01;
    after_edge();
    enable = 1'b0; D = 8'h00;
    #1;
    chk("cap_q_hold",  32'(q_hold),  32'h01);
    chk("cap_changed", 32'(changed), 32'h1);
    for (int i = 0; i < 5; i++) begin
      after_edge();
      chk("hold_q_hold",  32'(q_hold),  32'h01);
      chk("hold_changed", 32'(changed), 32'h0);
    end

    // Saturation of the 4-bit counter.
    reset_pulse();
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      D = WIDTH'($urandom);
      after_edge();
      chk("sat_cnt", 32'(upd_cnt), (i > 15) ? 32'd15 : 32'(i));
    end
    enable = 1'b0;
    after_edge();
    chk("sat_cnt_idle", 32'(upd_cnt), 32'd15);

    // Mid-run reset clears everything immediately.
    enable = 1'b1; D = 8'h01;
    after_edge();
    after_edge();
    after_edge();
    chk("mid_q_hold", 32'(q_hold), 32'h01);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q",       32'(Q),       32'h0);
    chk("mid_rst_q_hold",  32'(q_hold),  32'h0);
    chk("mid_rst_changed", 32'(changed), 32'h0);
    chk("mid_rst_upd_cnt", 32'(upd_cnt), 32'h0);
    rst_n = 1'b1;
    after_edge();
    chk("post_rst_changed", 32'(changed), 32'h1);
    chk("post_rst_upd_cnt", 32'(upd_cnt), 32'h1);

    // Random mix with small data range (so repeats occur) and rare resets.
    for (int i = 0; i < 300; i++) begin
      after_edge();
      enable = 1'($urandom_range(0, 1));
      D      = WIDTH'($urandom_range(0, 3));
      #1;
      chk("rand_q", 32'(Q), 32'(m_q()));
      if ($urandom_range(0, 40) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rand_rst_cnt", 32'(upd_cnt), 32'h0);
        rst_n = 1'b1;
      end
    end

    after_edge();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/d_latch.md
# d_latch

Gated data-capture block used as the session-3 storage primitive. A combinational gated output `Q` follows `D` while `enable` is high and is forced to 0 while `enable` is low. A clocked hold register keeps the last value of `D` that was enabled, and a change flag plus a saturating update counter give debug visibility. It sits between stimulus/data sources and downstream logic that needs a qualified data value.

## Interface

One clock; reset is asynchronous and active-low.

Parameters:
- `WIDTH`, default 1: data width of `D`, `Q`, `q_hold`.
- `CNT_WIDTH`, default 8: width of the update counter.

Ports:
- `clk`  input  1  system clock, rising-edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `D`  input  WIDTH  data in.
- `enable`  input  1  gate/capture enable, active-high.
- `Q`  output  WIDTH  gated data.
- `q_hold`  output  WIDTH  last enabled value of `D`, registered.
- `changed`  output  1  one-cycle pulse when `q_hold` takes a different value.
- `upd_cnt`  output  CNT_WIDTH  count of enabled clock edges, saturating.

## Operation

- Gated output `Q`, combinational:
  - `Q = D` when `rst_n`=1 and `enable`=1.
  - `Q = 0` otherwise, including whenever `rst_n`=0.
  - No storage on this path.
- Hold register:
  - On each rising `clk` edge with `enable`=1: `q_hold <= D`.
  - With `enable`=0: `q_hold` keeps its value.
- Change flag:
  - `changed` is registered. It goes to 1 for exactly one cycle on an enabled edge where the new `D` differs from the current `q_hold`.
  - Otherwise it is 0.
- Update counter:
  - `upd_cnt` increments by 1 on every enabled rising edge.
  - It saturates at all-ones and never wraps.
  - It does not change on disabled edges.
- Reset, asynchronous and taking effect immediately:
  - `Q`=0, `q_hold`=0, `changed`=0, `upd_cnt`=0.
  - Reset asserted mid-operation discards held state.
  - After release, the first enabled edge captures normally. The `changed` rule applies against 0.
- X-handling: `enable` is treated as a clean 0/1. There is no special X behaviour.

## Timing

- `Q`: zero-cycle latency. It is valid in the same simulation timestep as any `D`, `enable` or `rst_n` change, after combinational settle only.
- `q_hold`, `changed`, `upd_cnt`: one-cycle latency, updating on the rising `clk` edge that samples `enable`=1.
- Simultaneous `enable` fall and `clk` rise: the sampled value of `enable` (pre-edge) governs capture.
- `rst_n` deassertion is assumed synchronous to `clk` at system level. The block itself clears asynchronously.
- There are no handshakes and no backpressure. Every cycle is independent apart from `q_hold`/`upd_cnt` state.

## Test plan

- Reset: hold `rst_n`=0 with `D`=1 and `enable`=1 → `Q`=0, `q_hold`=0, `upd_cnt`=0, `changed`=0. Release → `Q`=1 immediately.
- Transparency: `enable`=1, drive 100 random `D` values → `Q`==`D` every step, with no clock edge required.
- Gating: `enable`=0, random `D` → `Q`==0 throughout. `q_hold` and `upd_cnt` stay unchanged across clock edges.
- Capture/hold: `enable`=1, `D`=1, one edge → `q_hold`=1, `changed`=1 for one cycle. Then `enable`=0, `D`=0 for 5 edges → `q_hold` stays 1 and `changed`=0.
- Counter saturation with `CNT_WIDTH`=4: 20 enabled edges → `upd_cnt`=15, held at 15.
- Reset mid-run: after several captures with `q_hold`=1, pulse `rst_n` low between edges → all outputs 0 immediately, without waiting for a clock edge.
